// File: rtl/continuous_monitoring_system_pkg.sv
// Shared widths and state type for the continuous monitoring system datapath.
// Trace packets are AXI_DATA_WIDTH wide; the DMA side consumes DMA_DATA_WIDTH beats.
package continuous_monitoring_system_pkg;

    localparam int AXI_DATA_WIDTH = 200;
    localparam int DMA_DATA_WIDTH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } cms_downsizer_state_t;

endpackage

// File: rtl/cms_stream_downsizer.sv
// Splits one IN_WIDTH trace packet into ceil(IN/OUT) OUT_WIDTH beats, LSB slice first; first beat 1 cycle after accept.
// Backpressure: input is refused while a packet drains; beats hold stable while M_AXIS_tready is low.
module cms_stream_downsizer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int IN_WIDTH  = AXI_DATA_WIDTH,
    parameter int OUT_WIDTH = DMA_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast,
    output logic                 M_AXIS_tuser,
    output logic [31:0]          packets_forwarded
);

    localparam int BEATS = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAD_W = BEATS * OUT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    cms_downsizer_state_t state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_WIDTH-1:0]  data_q, data_d;
    logic                 last_q, last_d;
    logic [31:0]          fwd_cnt_q, fwd_cnt_d;
    logic [PAD_W-1:0]     padded;
    logic                 sending;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        last_d    = last_q;
        fwd_cnt_d = fwd_cnt_q;
        case (state_q)
            IDLE: begin
                if (S_AXIS_tvalid) begin
                    data_d  = S_AXIS_tdata;
                    last_d  = S_AXIS_tlast;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (M_AXIS_tready) begin
                    if (idx_q == LAST_IDX) begin
                        fwd_cnt_d = fwd_cnt_q + 32'd1;
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            fwd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            last_q    <= last_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    // Outputs decode only flopped state, so nothing on S/M inputs reaches an output in the same cycle.
    always_comb begin
        padded  = PAD_W'(data_q);
        sending = (state_q == SEND);
    end

    assign S_AXIS_tready     = (state_q == IDLE);
    assign M_AXIS_tvalid     = sending;
    assign M_AXIS_tdata      = sending ? padded[idx_q*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign M_AXIS_tuser      = sending && (idx_q == '0);
    assign M_AXIS_tlast      = sending && (idx_q == LAST_IDX) && last_q;
    assign packets_forwarded = fwd_cnt_q;

endmodule

// File: tb/tb_cms_stream_downsizer.sv
// Directed bench for cms_stream_downsizer at IN_WIDTH=200, OUT_WIDTH=64 (4 beats per packet).
// Expected beats are queued at input handshake and popped as the DMA side accepts them.
module tb_cms_stream_downsizer;

    logic         clk;
    logic         rst;
    logic         s_vld;
    logic         s_rdy;
    logic [199:0] s_dat;
    logic         s_last;
    logic         m_vld;
    logic         m_rdy;
    logic [63:0]  m_dat;
    logic         m_last;
    logic         m_user;
    logic [31:0]  pf;

    int compared   = 0;
    int mismatched = 0;
    logic [65:0] sb[$];
    logic [31:0] exp_pf;

    cms_stream_downsizer #(
        .IN_WIDTH (200),
        .OUT_WIDTH(64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .S_AXIS_tvalid    (s_vld),
        .S_AXIS_tready    (s_rdy),
        .S_AXIS_tdata     (s_dat),
        .S_AXIS_tlast     (s_last),
        .M_AXIS_tvalid    (m_vld),
        .M_AXIS_tready    (m_rdy),
        .M_AXIS_tdata     (m_dat),
        .M_AXIS_tlast     (m_last),
        .M_AXIS_tuser     (m_user),
        .packets_forwarded(pf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [65:0] exp_beat(input logic [199:0] pkt, input int k, input logic last);
        logic [255:0] p;
        p = {56'h0, pkt};
        return {p[k*64 +: 64], (k == 0), ((k == 3) && last)};
    endfunction

    // Scoreboard side: a beat transfers at the next posedge when valid and ready are both high here.
    always begin
        @(negedge clk);
        #1;
        if (!rst && m_vld && m_rdy) begin
            if (sb.size() == 0)
                check("unexpected_beat", {m_dat, m_user, m_last}, 66'h0);
            else
                check("beat", {m_dat, m_user, m_last}, sb.pop_front());
        end
    end

    // Returns at the negedge just after the input handshake, with beat 0 visible.
    task automatic send_pkt(input logic [199:0] pkt, input logic last, input logic keep_vld);
        int n;
        s_vld  = 1'b1;
        s_dat  = pkt;
        s_last = last;
        n = 0;
        while (!s_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", {65'h0, s_rdy}, 66'h1);
        for (int k = 0; k < 4; k++) sb.push_back(exp_beat(pkt, k, last));
        @(negedge clk);
        if (!keep_vld) s_vld = 1'b0;
        check("first_beat_latency", {64'h0, m_vld, m_user}, 66'h3);
    endtask

    task automatic drain(input logic rand_rdy);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            if (rand_rdy) m_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        m_rdy = 1'b1;
        @(negedge clk);
        check("drain", 66'(sb.size()), 66'h0);
    endtask

    logic [199:0] pkt0, pkt1, pkt2, pkt3;
    int gap;

    initial begin
        rst    = 1'b1;
        s_vld  = 1'b0;
        s_dat  = '0;
        s_last = 1'b0;
        m_rdy  = 1'b1;
        exp_pf = 32'd0;
        pkt0 = {8'hAA, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h55AA_55AA_0000_BBBB};
        pkt1 = {8'h3C, 64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0, 64'h0F0F_F0F0_1234_5678};
        pkt2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        pkt3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)};

        repeat (2) @(negedge clk);
        check("rst_tready", {65'h0, s_rdy}, 66'h1);
        check("rst_m_outputs", {m_dat, m_user, m_last}, 66'h0);
        check("rst_tvalid", {65'h0, m_vld}, 66'h0);
        check("rst_count", {34'h0, pf}, 66'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single packet with tlast, DMA always ready.
        send_pkt(pkt0, 1'b1, 1'b0);
        drain(1'b0);
        exp_pf++;
        check("count_after_tlast_pkt", {34'h0, pf}, {34'h0, exp_pf});

        // Same packet without tlast: M_AXIS_tlast must stay low on every beat.
        send_pkt(pkt0, 1'b0, 1'b0);
        drain(1'b0);
        exp_pf++;
        check("count_after_plain_pkt", {34'h0, pf}, {34'h0, exp_pf});

        // Five-cycle stall on beat 1.
        send_pkt(pkt1, 1'b1, 1'b0);
        @(negedge clk);
        m_rdy = 1'b0;
        repeat (5) begin
            check("stall_beat1_hold", {m_dat, m_user, m_last}, exp_beat(pkt1, 1, 1'b1));
            check("stall_valid", {65'h0, m_vld}, 66'h1);
            @(negedge clk);
        end
        m_rdy = 1'b1;
        drain(1'b0);
        exp_pf++;
        check("count_after_stall", {34'h0, pf}, {34'h0, exp_pf});

        // Back-to-back packets with S_AXIS_tvalid held high.
        send_pkt(pkt2, 1'b1, 1'b1);
        gap = 0;
        while (!s_rdy && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_tready_gap", 66'(gap), 66'd4);
        send_pkt(pkt3, 1'b0, 1'b0);
        drain(1'b0);
        exp_pf += 2;
        check("count_after_b2b", {34'h0, pf}, {34'h0, exp_pf});

        // Random DMA backpressure.
        send_pkt(pkt3, 1'b1, 1'b0);
        drain(1'b1);
        exp_pf++;
        check("count_after_random_rdy", {34'h0, pf}, {34'h0, exp_pf});

        // Reset while beat 2 is on the bus.
        send_pkt(pkt1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_beat2", {m_dat, m_user, m_last}, exp_beat(pkt1, 2, 1'b1));
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_pf = 32'd0;
        check("midpkt_reset_tvalid", {65'h0, m_vld}, 66'h0);
        check("midpkt_reset_count", {34'h0, pf}, 66'h0);
        check("midpkt_reset_tready", {65'h0, s_rdy}, 66'h1);
        send_pkt(pkt2, 1'b1, 1'b0);
        drain(1'b0);
        exp_pf++;
        check("count_after_reset_pkt", {34'h0, pf}, {34'h0, exp_pf});

        // Counter wrap from all-ones.
        force dut.fwd_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.fwd_cnt_q;
        @(negedge clk);
        check("preload_count", {34'h0, pf}, {34'h0, 32'hFFFF_FFFF});
        send_pkt(pkt0, 1'b1, 1'b0);
        drain(1'b0);
        check("count_wrap", {34'h0, pf}, 66'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cms_stream_downsizer.md
CMS_STREAM_DOWNSIZER -- requirements
Module: cms_stream_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default AXI_DATA_WIDTH, width of one trace packet from the monitoring stage.
REQ-002 SHALL have parameter OUT_WIDTH, default DMA_DATA_WIDTH (64), width of one output beat toward the DMA.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous reset, active-high (decided: one clock, synchronous active-high reset).
REQ-005 Port S_AXIS_tvalid  input  1  packet valid from the monitoring stage.
REQ-006 Port S_AXIS_tready  output  1  packet accepted when high with S_AXIS_tvalid.
REQ-007 Port S_AXIS_tdata  input  IN_WIDTH  packet payload.
REQ-008 Port S_AXIS_tlast  input  1  packet closes a DMA transfer.
REQ-009 Port M_AXIS_tvalid  output  1  beat valid.
REQ-010 Port M_AXIS_tready  input  1  DMA accepts beat.
REQ-011 Port M_AXIS_tdata  output  OUT_WIDTH  beat payload.
REQ-012 Port M_AXIS_tlast  output  1  final beat of a packet whose S_AXIS_tlast was set.
REQ-013 Port M_AXIS_tuser  output  1  first beat of each packet.
REQ-014 Port packets_forwarded  output  32  count of packets whose final beat was accepted.

Function
REQ-015 BEATS SHALL equal ceil(IN_WIDTH/OUT_WIDTH); the beat index SHALL be $clog2(BEATS) bits wide, minimum 1.
REQ-016 The captured packet SHALL be zero-extended to BEATS*OUT_WIDTH bits; beat k SHALL carry bits [k*OUT_WIDTH +: OUT_WIDTH], LSB slice first.
REQ-017 The FSM SHALL have two states: IDLE and SEND.
REQ-018 In IDLE: S_AXIS_tready=1, M_AXIS_tvalid=0.
REQ-019 In IDLE with S_AXIS_tvalid=1: capture tdata and tlast, set beat index to 0, enter SEND next cycle.
REQ-020 In SEND: S_AXIS_tready=0, M_AXIS_tvalid=1.
REQ-021 In SEND, M_AXIS_tdata SHALL be the indexed slice, M_AXIS_tuser=(index==0), M_AXIS_tlast=(index==BEATS-1)&captured_tlast.
REQ-022 In SEND with M_AXIS_tready=1 and index<BEATS-1: increment index, stay in SEND.
REQ-023 In SEND with M_AXIS_tready=1 and index==BEATS-1: increment packets_forwarded, return to IDLE.
REQ-024 In SEND with M_AXIS_tready=0: tdata, tlast, tuser and index SHALL hold (AXI stability).
REQ-025 Latency: first beat valid 1 cycle after input handshake; one packet costs BEATS+1 cycles minimum.
REQ-026 BEATS==1: the single beat SHALL carry tuser=1 and tlast=captured_tlast.
REQ-027 packets_forwarded SHALL wrap 0xFFFFFFFF->0 without saturation.
REQ-028 S_AXIS_tready and all M_AXIS outputs SHALL be driven from registered state only; there is no combinational path from any input to any output.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, index=0, captured data/tlast=0, packets_forwarded=0.
REQ-030 Reset mid-packet SHALL discard remaining beats; M_AXIS_tvalid=0 on the cycle after the reset edge.
REQ-031 After reset: S_AXIS_tready=1, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, M_AXIS_tuser=0.

Structure
REQ-032 DMA_DATA_WIDTH (64) and the state enum typedef cms_downsizer_state_t SHALL live in continuous_monitoring_system_pkg, next to AXI_DATA_WIDTH.
REQ-033 The block SHALL be self-contained with no sub-module; the FSM, the slice mux and the counter are inline.

Verification (IN_WIDTH=200, OUT_WIDTH=64, BEATS=4)
REQ-034 Packet 0x...AA_BBBB with tlast=1, M_AXIS_tready held 1 -> 4 beats on consecutive cycles, starting 1 cycle after the input handshake; beat 3 has upper 56 bits zero, tuser only on beat 0, tlast only on beat 3; packets_forwarded=1.
REQ-035 Same packet with tlast=0 -> 4 beats, M_AXIS_tlast never asserted.
REQ-036 M_AXIS_tready=0 for 5 cycles during beat 1 -> beat 1 held stable all 5 cycles, no beat lost or duplicated.
REQ-037 Two packets back-to-back with S_AXIS_tvalid held 1 -> S_AXIS_tready low for 4 cycles between acceptances; 8 beats out in order.
REQ-038 rst pulsed during beat 2 -> M_AXIS_tvalid=0 on the next cycle, packets_forwarded=0, next packet starts at beat 0 with tuser=1.
REQ-039 Preload packets_forwarded to 0xFFFFFFFF (force), complete one packet -> counter reads 0.
